// File: rtl/fifo_pkt_rd.sv
// Read-side packetiser: drains a dual-clock FIFO read port into fixed-length
// sop/eop-framed packets on a valid/ready stream, absorbing read latency in a 3-deep buffer.
//
// state | meaning
// IDLE  | waiting for a full packet to be resident in the FIFO
// BURST | issuing rdreq for the current packet, throttled by buffer space
// GAP   | one settle cycle so rdusedw reflects the last read before IDLE re-checks
module fifo_pkt_rd #(
  parameter int kuan    = 16,
  parameter int shenbit = 11,
  parameter int pkt_len = 256
) (
  input  logic               rdclk,
  input  logic               aclr,
  input  logic [shenbit-1:0] rdusedw,
  input  logic [kuan-1:0]    fifo_q,
  output logic               rdreq,
  output logic [kuan-1:0]    out_data,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  input  logic               out_ready,
  output logic [15:0]        pkt_cnt
);

  localparam logic [shenbit-1:0] LEN  = shenbit'(pkt_len);
  localparam logic [shenbit-1:0] LAST = shenbit'(pkt_len - 1);
  localparam logic [shenbit-1:0] ONE  = shenbit'(1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t             state;
  logic [shenbit-1:0] issued;
  logic [shenbit-1:0] widx;
  logic               inflight;
  logic [1:0]         occ;
  logic [1:0]         head;
  logic [1:0]         tail;
  logic [kuan-1:0]    buf_data [3];
  logic [2:0]         buf_sop;
  logic [2:0]         buf_eop;
  logic               push;
  logic               pop;
  logic [2:0]         space_used;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Counting the in-flight word reserves its slot before it lands.
  assign space_used = {1'b0, occ} + {2'b00, inflight};
  assign rdreq      = (state == BURST) && (issued < LEN) && (space_used < 3'd3);

  assign push      = inflight;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = buf_data[head];
  assign out_sop   = out_valid && buf_sop[head];
  assign out_eop   = out_valid && buf_eop[head];

  always_ff @(posedge rdclk or negedge aclr) begin
    if (!aclr) begin
      state  <= IDLE;
      issued <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rdusedw >= LEN) state <= BURST;
        end
        BURST: begin
          if (rdreq) begin
            if (issued == LAST) begin
              issued <= '0;
              state  <= GAP;
            end else begin
              issued <= issued + ONE;
            end
          end
        end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge rdclk or negedge aclr) begin
    if (!aclr) inflight <= 1'b0;
    else       inflight <= rdreq;
  end

  always_ff @(posedge rdclk or negedge aclr) begin
    if (!aclr) begin
      head    <= 2'd0;
      tail    <= 2'd0;
      occ     <= 2'd0;
      widx    <= '0;
      buf_sop <= 3'b000;
      buf_eop <= 3'b000;
      for (int i = 0; i < 3; i++) buf_data[i] <= '0;
    end else begin
      if (push) begin
        buf_data[tail] <= fifo_q;
        buf_sop[tail]  <= (widx == '0);
        buf_eop[tail]  <= (widx == LAST);
        tail           <= ptr_inc(tail);
        widx           <= (widx == LAST) ? '0 : widx + ONE;
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge rdclk or negedge aclr) begin
    if (!aclr)                pkt_cnt <= 16'd0;
    else if (pop && out_eop)  pkt_cnt <= pkt_cnt + 16'd1;
  end

  // The rdreq space rule makes this unreachable; a hit means the throttle is broken.
  a_no_overflow: assert property (@(posedge rdclk) disable iff (!aclr) !(push && occ == 2'd3));

endmodule
